// File: rtl/mul_pkg.sv
// Shared fixed-point format and FSM state encoding for the multiplier and the divider.
package mul_pkg;

    // Default operand/result width and fractional bit count.
    localparam int DEF_WIDTH = 10;
    localparam int DEF_FRAC  = 5;

    // Sequencing states for the iterative arithmetic units.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_controller.sv
// Sequencer for the shift-add multiplier: IDLE -> CALC (WIDTH steps) -> DONE -> IDLE.
module mul_controller
    import mul_pkg::*;
(
    input  logic clk,
    input  logic rst,       // asynchronous, active-low
    input  logic start_i,   // only honoured in IDLE
    input  logic last_i,    // datapath is on its final step
    output logic busy_o,
    output logic valid_o,
    output logic load_o,    // capture operands, clear accumulator/counter
    output logic shift_o    // perform one shift-add step
);

    state_t state_q;
    logic   busy_q;
    logic   valid_q;

    // State register with registered busy/valid outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (start_i) begin
                        state_q <= CALC;
                        busy_q  <= 1'b1;
                    end
                end
                CALC: begin
                    if (last_i) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; a held start is
                    // picked up on the following IDLE edge.
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    // Load happens on the same edge that samples start so operands are taken
    // exactly when the request is accepted.
    assign load_o  = (state_q == IDLE) && start_i;
    assign shift_o = (state_q == CALC);

endmodule

// File: rtl/mul_top.sv
// Iterative unsigned fixed-point multiplier: one shift-add step per cycle,
// result truncated back to the operand format with an overflow flag.
module mul_top
    import mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             valid,
    output logic             ov
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               ov_q, ov_d;
    logic [WIDTH:0]     sum;
    logic               load, shift, last, finish;

    mul_controller u_ctrl (
        .clk     (clk),
        .rst     (rst),
        .start_i (start),
        .last_i  (last),
        .busy_o  (busy),
        .valid_o (valid),
        .load_o  (load),
        .shift_o (shift)
    );

    assign last   = (cnt_q == CNT_W'(WIDTH - 1));
    assign finish = shift && last;

    // Next-state datapath: the multiplier shifts right so bit 0 is always the
    // current bit; the accumulator high half absorbs the add and the whole
    // accumulator shifts right, leaving the full product after WIDTH steps.
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        q_d   = q_q;
        ov_d  = ov_q;
        sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
        if (load) begin
            a_d   = A;
            b_d   = B;
            acc_d = '0;
            cnt_d = '0;
        end else if (shift) begin
            acc_d = {sum, acc_q[WIDTH-1:1]};
            b_d   = b_q >> 1;
            cnt_d = cnt_q + 1'b1;
            if (finish) begin
                q_d  = acc_d[FRAC+WIDTH-1:FRAC];
                ov_d = |acc_d[2*WIDTH-1:FRAC+WIDTH];
            end
        end
    end

    // Datapath registers; result and flag only change when DONE is entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            ov_q  <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            q_q   <= q_d;
            ov_q  <= ov_d;
        end
    end

    assign Q  = q_q;
    assign ov = ov_q;

endmodule

// File: tb/tb_mul_top.sv
// Directed bench for mul_top with hand-computed products.
module tb_mul_top;

    localparam int WIDTH = 10;
    localparam int FRAC  = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic             busy;
    logic             valid;
    logic             ov;

    int n_checks = 0;
    int n_fail   = 0;

    mul_top #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .busy  (busy),
        .valid (valid),
        .ov    (ov)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One full operation; operands are scrambled right after capture.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] exp_q, input logic exp_ov);
        int  n;
        bit  got;
        @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = ~a; B = ~b;
        check({tag, "_busy"}, busy, 1);
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (valid) got = 1;
        end
        check({tag, "_latency"}, n + 1, WIDTH + 1);
        check({tag, "_q"}, Q, exp_q);
        check({tag, "_ov"}, ov, exp_ov);
        check({tag, "_busy_done"}, busy, 0);
        @(posedge clk); #1;
        check({tag, "_valid_once"}, valid, 0);
        check({tag, "_q_hold"}, Q, exp_q);
        check({tag, "_ov_hold"}, ov, exp_ov);
    endtask

    initial begin
        int vcnt;
        int vcyc;
        int vcyc2;
        logic [WIDTH-1:0] qv;
        logic [WIDTH-1:0] qv2;

        rst = 1'b0; start = 1'b0; A = '0; B = '0;
        #1;
        check("reset_q", Q, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", valid, 0);
        check("reset_ov", ov, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        // 191 * 24 = 4584 -> >>5 = 143
        run_op("basic", 10'b0010111111, 10'b0000011000, 10'b0010001111, 1'b0);
        // zero multiplier, no early finish
        run_op("zero", 10'b1101010000, 10'b0000000000, 10'b0000000000, 1'b0);

        // 340 * 1.0 with a stray start at cycle 4
        @(negedge clk);
        A = 10'b0101010100; B = 10'b0000100000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        vcnt = 0; vcyc = 0; qv = '0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            start = (c == 4);
            @(posedge clk); #1;
            if (valid) begin
                vcnt++;
                vcyc = c;
                qv   = Q;
            end
        end
        start = 1'b0;
        check("ignore_valid_count", vcnt, 1);
        check("ignore_valid_cycle", vcyc, WIDTH);
        check("ignore_q", qv, 10'b0101010100);
        check("ignore_ov", ov, 0);

        // 511 * 511 = 261121 -> Q = 992, overflow
        run_op("ovf", 10'b0111111111, 10'b0111111111, 10'b1111100000, 1'b1);

        // abort with reset mid-calculation
        @(negedge clk);
        A = 10'b0010111111; B = 10'b0000011000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_q", Q, 0);
        check("abort_ov", ov, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        @(posedge clk); #1;
        check("abort_busy_held", busy, 0);
        @(negedge clk) rst = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (valid || busy) vcnt++;
        end
        check("abort_no_pulse", vcnt, 0);
        run_op("after_abort", 10'b0010111111, 10'b0000011000, 10'b0010001111, 1'b0);

        // start held high: back-to-back operations every WIDTH+2 edges
        @(negedge clk);
        A = 10'b0010111111; B = 10'b0000011000; start = 1'b1;
        vcnt = 0; vcyc = -1; vcyc2 = -1; qv = '0; qv2 = '0;
        for (int c = 0; c <= 30; c++) begin
            @(posedge clk); #1;
            if (valid) begin
                if (vcnt == 0) begin vcyc = c;  qv  = Q; end
                else           begin vcyc2 = c; qv2 = Q; end
                vcnt++;
            end
        end
        @(negedge clk) start = 1'b0;
        check("held_count", vcnt, 2);
        check("held_first", vcyc, WIDTH);
        check("held_second", vcyc2, 2 * WIDTH + 2);
        check("held_q1", qv, 10'b0010001111);
        check("held_q2", qv2, 10'b0010001111);
        repeat (15) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_top.md
MUL_TOP -- requirements
Module: mul_top

Interface
REQ-001 The module SHALL have parameter WIDTH, default 10, operand and result width in bits.
REQ-002 The module SHALL have parameter FRAC, default 5, number of fractional bits in the unsigned fixed-point operand and result format.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port start  input  1  request to begin a multiplication, sampled only in IDLE.
REQ-006 The module SHALL have port A  input  WIDTH  multiplicand, unsigned fixed-point.
REQ-007 The module SHALL have port B  input  WIDTH  multiplier, unsigned fixed-point.
REQ-008 The module SHALL have port Q  output  WIDTH  product, truncated to the operand format.
REQ-009 The module SHALL have port busy  output  1  high while a multiplication is in progress.
REQ-010 The module SHALL have port valid  output  1  one-cycle pulse marking Q and ov as updated.
REQ-011 The module SHALL have port ov  output  1  overflow flag: the integer part of the product exceeds the result width.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
REQ-013 In IDLE, start=1 at a clock edge SHALL capture A and B, clear the 2*WIDTH accumulator and iteration counter, and enter CALC, with busy=1 from the next cycle.
REQ-014 In CALC, each cycle SHALL perform one shift-add step (add the captured multiplicand into the accumulator when the current multiplier bit is 1, then shift) and increment the counter.
REQ-015 After exactly WIDTH CALC cycles, the FSM SHALL enter DONE.
REQ-016 On entering DONE, Q SHALL be set to bits [FRAC+WIDTH-1:FRAC] of the full product (truncation, no rounding).
REQ-017 On entering DONE, ov SHALL be set to 1 if and only if any of product bits [2*WIDTH-1:FRAC+WIDTH] is nonzero.
REQ-018 In DONE, valid SHALL be 1 and busy SHALL be 0 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-019 Latency SHALL be WIDTH+1 cycles from the edge that samples start to the cycle in which valid=1 (11 cycles at default).
REQ-020 Q and ov SHALL hold their values until the next DONE or reset.
REQ-021 start asserted in CALC or DONE SHALL be ignored; changes on A or B after capture SHALL NOT affect the result.
REQ-022 start held high continuously SHALL begin a new operation on the first IDLE edge after each DONE.
REQ-023 A zero operand SHALL produce Q=0 and ov=0 with normal latency; there is no early termination.

Reset
REQ-024 rst=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, Q=0, ov=0, busy=0, valid=0, and clear the accumulator and counter.
REQ-025 Reset asserted during CALC SHALL abort the operation with no valid pulse; after release, the block SHALL accept a new start normally.

Structure
REQ-026 A shared package mul_pkg SHALL hold the default WIDTH and FRAC constants and the FSM state typedef, so that the divider and multiplier share a single format definition.
REQ-027 The design SHALL be split into mul_top, containing the datapath (operand registers, accumulator, counter), and one sub-module, mul_controller, containing the FSM and the busy/valid/load/shift controls.

Verification
REQ-028 A=0010111111, B=0000011000, 10 ns start pulse -> after 11 cycles valid=1, Q=0010001111, ov=0.
REQ-029 A=0111111111, B=0111111111 -> Q=1111100000, ov=1.
REQ-030 A=1101010000, B=0000000000 -> Q=0000000000, ov=0, latency 11 cycles.
REQ-031 A=0101010100, B=0000100000 (1.0) -> Q=0101010100, ov=0; a second start pulse at cycle 4 is ignored, and exactly one valid pulse occurs.
REQ-032 rst driven low at cycle 5 of an operation -> all outputs 0 immediately with no valid pulse; a following operation with A=0010111111, B=0000011000 still yields Q=0010001111.
